sfx_sequencer: RTL and testbench

Game-event sound sequencer sitting directly upstream of the audio processing unit. It latches one-cycle game event strobes, selects one by fixed priority, and plays a short, hard-coded pattern of channel-trigger masks. Patterns advance once per video frame and drive the APU's `saw_trigger`, `square_trigger` and `noise_trigger` inputs. All outputs are registered and change only on frame boundaries.

---
 rtl/sfx_sequencer.sv | 138 +++++++++++++
 tb/tb_sfx_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// Game-event sound sequencer: latches event strobes and plays fixed per-frame trigger patterns.
// Optional macro SFX_QUEUE_EN keeps unstarted events pending instead of dropping them.
module sfx_sequencer #(
    parameter int NUM_STEPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       sfx_enable,
    input  logic       ev_pickup,
    input  logic       ev_shoot,
    input  logic       ev_hit,
    input  logic       ev_explode,
    output logic       saw_trigger,
    output logic       square_trigger,
    output logic       noise_trigger,
    output logic       busy,
    output logic [1:0] cur_sfx
);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t     state_q, state_d;
    logic [1:0] cur_q, cur_d;
    logic [1:0] step_q, step_d;
    logic [3:0] timer_q, timer_d;
    logic [2:0] mask_q, mask_d;
    logic [3:0] pend_q, pend_d;

    logic [3:0] ev_vec;
    logic [3:0] pend_keep;
    logic [1:0] prio;
    logic       prio_vld;
    logic [1:0] step_nxt;
    logic [6:0] rom_start;
    logic [6:0] rom_next;
    logic       last_step;

    // Pattern ROM, {mask[2:0] = {noise,square,saw}, duration[3:0]}; zero duration ends a pattern.
    function automatic logic [6:0] rom(input logic [3:0] addr);
        case (addr)
            4'b11_00: rom = {3'b100, 4'd8};
            4'b11_01: rom = {3'b101, 4'd8};
            4'b11_10: rom = {3'b100, 4'd8};
            4'b11_11: rom = {3'b100, 4'd6};
            4'b10_00: rom = {3'b110, 4'd4};
            4'b10_01: rom = {3'b010, 4'd4};
            4'b10_10: rom = {3'b100, 4'd2};
            4'b01_00: rom = {3'b001, 4'd3};
            4'b01_01: rom = {3'b001, 4'd3};
            4'b00_00: rom = {3'b010, 4'd4};
            4'b00_01: rom = {3'b000, 4'd2};
            4'b00_10: rom = {3'b010, 4'd4};
            default:  rom = 7'd0;
        endcase
    endfunction

    assign ev_vec    = {ev_explode, ev_hit, ev_shoot, ev_pickup};
    assign prio_vld  = |pend_q;
    assign prio      = pend_q[3] ? 2'd3 : pend_q[2] ? 2'd2 : pend_q[1] ? 2'd1 : 2'd0;
    assign step_nxt  = step_q + 2'd1;
    assign rom_start = rom({prio, 2'b00});
    assign rom_next  = rom({cur_q, step_nxt});
    assign last_step = (step_q == 2'(NUM_STEPS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= 2'd0;
            step_q  <= 2'd0;
            timer_q <= 4'd0;
            mask_q  <= 3'd0;
            pend_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        step_d  = step_q;
        timer_d = timer_q;
        mask_d  = mask_q;
        pend_d  = pend_q | ev_vec;
`ifdef SFX_QUEUE_EN
        pend_keep = pend_q;
`else
        pend_keep = 4'd0;
`endif

        if (!sfx_enable) begin
            state_d = S_IDLE;
            cur_d   = 2'd0;
            step_d  = 2'd0;
            timer_d = 4'd0;
            mask_d  = 3'd0;
            pend_d  = 4'd0;
        end else if (frame_start) begin
            // Strobes arriving with this frame_start are latched but only seen at the next one.
            if (prio_vld && (state_q == S_IDLE || prio > cur_q)) begin
                state_d         = S_PLAY;
                cur_d           = prio;
                step_d          = 2'd0;
                mask_d          = rom_start[6:4];
                timer_d         = rom_start[3:0];
                pend_keep[prio] = 1'b0;
            end else if (state_q == S_PLAY && timer_q == 4'd1) begin
                if (last_step || rom_next[3:0] == 4'd0) begin
                    state_d = S_IDLE;
                    cur_d   = 2'd0;
                    step_d  = 2'd0;
                    timer_d = 4'd0;
                    mask_d  = 3'd0;
                end else begin
                    step_d  = step_nxt;
                    mask_d  = rom_next[6:4];
                    timer_d = rom_next[3:0];
                end
            end else if (state_q == S_PLAY) begin
                timer_d = timer_q - 4'd1;
            end
            pend_d = pend_keep | ev_vec;
        end
    end

    assign saw_trigger    = mask_q[0];
    assign square_trigger = mask_q[1];
    assign noise_trigger  = mask_q[2];
    assign busy           = (state_q == S_PLAY);
    assign cur_sfx        = cur_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench for sfx_sequencer: per-frame expected outputs are queued from a pattern table and popped at each frame.
module tb_sfx_sequencer;

    localparam int FL = 6;
    localparam logic [3:0] PICKUP  = 4'b0001;
    localparam logic [3:0] SHOOT   = 4'b0010;
    localparam logic [3:0] HIT     = 4'b0100;
    localparam logic [3:0] EXPLODE = 4'b1000;

    logic       clk = 1'b0;
    logic       reset, frame_start, sfx_enable;
    logic [3:0] ev;
    logic       saw_trigger, square_trigger, noise_trigger, busy;
    logic [1:0] cur_sfx;

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_q[$];
    logic [2:0] pm[4][4];
    logic [3:0] pd[4][4];

    always #5 clk = ~clk;

    sfx_sequencer #(.NUM_STEPS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .sfx_enable    (sfx_enable),
        .ev_pickup     (ev[0]),
        .ev_shoot      (ev[1]),
        .ev_hit        (ev[2]),
        .ev_explode    (ev[3]),
        .saw_trigger   (saw_trigger),
        .square_trigger(square_trigger),
        .noise_trigger (noise_trigger),
        .busy          (busy),
        .cur_sfx       (cur_sfx)
    );

    function automatic logic [5:0] obs();
        return {noise_trigger, square_trigger, saw_trigger, busy, cur_sfx};
    endfunction

    task automatic check(input string tag, input logic [5:0] o, input logic [5:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed={nsq_saw,busy,cur}=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic cyc(input logic fs, input logic [3:0] e);
        frame_start = fs;
        ev          = e;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        ev          = 4'd0;
    endtask

    // One frame: frame_start on cycle 0, optional strobe at the same edge, optional strobe mid-frame.
    task automatic frame(input logic [3:0] ev_mid, input logic [3:0] ev_fs, input string tag);
        logic [5:0] e;
        cyc(1'b1, ev_fs);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=%b expected=entry", tag, obs());
            e = 6'd0;
        end else begin
            e = exp_q.pop_front();
        end
        check({tag, "_fs1"}, obs(), e);
        for (int c = 1; c < FL; c++) cyc(1'b0, (c == 2) ? ev_mid : 4'd0);
        check({tag, "_hold"}, obs(), e);
    endtask

    task automatic frames(input int n, input int k, input logic [3:0] ev_mid, input string tag);
        for (int i = 0; i < n; i++) frame((i == k) ? ev_mid : 4'd0, 4'd0, tag);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(6'd0);
    endtask

    task automatic push_pat(input int e, input int skip, input int n);
        int f;
        f = 0;
        for (int s = 0; s < 4; s++)
            for (int d = 0; d < int'(pd[e][s]); d++) begin
                if (f >= skip && f < skip + n) exp_q.push_back({pm[e][s], 1'b1, 2'(e)});
                f++;
            end
    endtask

    initial begin
        int n;
        pm = '{'{3'b010, 3'b000, 3'b010, 3'b000},
               '{3'b001, 3'b001, 3'b000, 3'b000},
               '{3'b110, 3'b010, 3'b100, 3'b000},
               '{3'b100, 3'b101, 3'b100, 3'b100}};
        pd = '{'{4'd4, 4'd2, 4'd4, 4'd0},
               '{4'd3, 4'd3, 4'd0, 4'd0},
               '{4'd4, 4'd4, 4'd2, 4'd0},
               '{4'd8, 4'd8, 4'd8, 4'd6}};

        reset = 1'b1; sfx_enable = 1'b1; frame_start = 1'b0; ev = 4'd0;
        cyc(1'b0, 4'd0); cyc(1'b1, EXPLODE); cyc(1'b0, HIT);
        check("reset", obs(), 6'd0);
        reset = 1'b0;
        cyc(1'b0, 4'd0);

        // Single shoot: saw for 6 frames.
        push_idle(1); push_pat(1, 0, 6); push_idle(2);
        frames(9, 0, SHOOT, "shoot");

        // Same-frame pickup + hit: hit wins.
        push_idle(1); push_pat(2, 0, 10);
`ifdef SFX_QUEUE_EN
        push_idle(1); push_pat(0, 0, 10); push_idle(1);
`else
        push_idle(2);
`endif
        n = exp_q.size();
        frames(n, 0, HIT | PICKUP, "prio");

        // Explode preempts shoot in its 2nd frame; a later shoot does not preempt explode.
        push_idle(1); push_pat(1, 0, 2); push_pat(3, 0, 30); push_idle(1);
`ifdef SFX_QUEUE_EN
        push_pat(1, 0, 6); push_idle(1);
`endif
        n = exp_q.size();
        for (int i = 0; i < n; i++)
            frame((i == 0) ? SHOOT : (i == 2) ? EXPLODE : (i == 10) ? SHOOT : 4'd0, 4'd0, "preempt");

        // Strobe coincident with frame_start is served one frame later.
        push_idle(1); push_pat(0, 0, 10); push_idle(1);
        frame(4'd0, PICKUP, "coinc");
        frames(11, -1, 4'd0, "coinc");

        // Mute mid-explode, strobe while muted is ignored.
        push_idle(1); push_pat(3, 0, 3);
        frames(4, 0, EXPLODE, "pre_mute");
        sfx_enable = 1'b0;
        cyc(1'b0, 4'd0);
        check("mute", obs(), 6'd0);
        cyc(1'b1, HIT); cyc(1'b0, HIT); cyc(1'b0, 4'd0);
        check("muted_hold", obs(), 6'd0);
        sfx_enable = 1'b1;
        push_idle(3);
        frames(3, -1, 4'd0, "unmute");

        // Reset during pickup step 0 with a hit pending.
        push_idle(1); push_pat(0, 0, 2);
        frames(3, 0, PICKUP, "pre_reset");
        cyc(1'b0, HIT);
        reset = 1'b1;
        cyc(1'b0, 4'd0);
        check("reset_mid", obs(), 6'd0);
        reset = 1'b0;
        push_idle(3);
        frames(3, -1, 4'd0, "post_reset");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL sb_drain observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
